sepconv_resample_stage: RTL

Parametrised post-processing stage placed directly after a separable-convolution layer (depthwise + pointwise) in the CNN datapath. It accepts one multi-channel pixel per valid cycle in raster order, tracks row/column position, and emits either every pixel, a stride-2 decimated stream, or a signed 2x2 max-pooled stream, selected per frame. It generalises the fixed 64-channel, 44x44 layer wrappers to any channel count and image size, and adds frame-boundary signalling.

---
 rtl/sepconv_resample_stage_pkg.sv | 22 ++
 rtl/sepconv_chan_max.sv | 23 ++
 rtl/sepconv_resample_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sepconv_resample_stage_pkg.sv
// Shared definitions for the separable-convolution resample stage.
//
// Contents:
//   mode_e     - per-frame output mode (pass / stride-2 decimate / 2x2 max-pool)
//   cnt_width  - bit width of a position counter for a given dimension
//
// Optional feature macro used by the stage: SEPCONV_MAXPOOL_EN.
package sepconv_resample_stage_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_DEC2  = 2'd1,
        MODE_POOL2 = 2'd2
    } mode_e;

    // clog2 of the dimension, never narrower than one bit so that a
    // dimension of 1 or 2 still yields a usable counter/index.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sepconv_chan_max.sv
// Per-channel signed maximum of two packed multi-channel pixels.
// Purely combinational.
//
// Ports:
//   a, b  - packed pixels, channel c at [c*DATA_WIDHT +: DATA_WIDHT]
//   y     - per-channel signed max(a, b), same packing
module sepconv_chan_max #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 64
) (
    input  logic [DATA_WIDHT*CHANNELS-1:0] a,
    input  logic [DATA_WIDHT*CHANNELS-1:0] b,
    output logic [DATA_WIDHT*CHANNELS-1:0] y
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign y[c*DATA_WIDHT +: DATA_WIDHT] =
            ($signed(a[c*DATA_WIDHT +: DATA_WIDHT]) > $signed(b[c*DATA_WIDHT +: DATA_WIDHT]))
                ? a[c*DATA_WIDHT +: DATA_WIDHT]
                : b[c*DATA_WIDHT +: DATA_WIDHT];
    end

endmodule

// File: rtl/sepconv_resample_stage.sv
// Post-processing stage after a separable-convolution layer. Takes one
// multi-channel pixel per valid cycle in raster order and emits every pixel,
// a stride-2 decimated stream, or a signed 2x2 max-pooled stream. The mode is
// sampled once per frame, on the frame's first valid pixel.
//
// Build option: SEPCONV_MAXPOOL_EN. When defined, mode 2 max-pools using a
// half-row line buffer and two comparator banks. When undefined, none of that
// is built and mode 2 behaves exactly like mode 1.
//
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   Data_In    - input pixel, all channels packed
//   Valid_In   - Data_In valid this cycle
//   Mode       - 0 pass, 1 decimate, 2 max-pool, 3 same as 0
//   Data_Out   - output pixel (registered)
//   Valid_Out  - Data_Out valid this cycle
//   Last_Out   - marks the final output pixel of a frame
//
// Handshake: valid-only, no ready. Each cycle with Valid_In high delivers
// exactly one pixel; each qualifying pixel produces one single-cycle
// Valid_Out pulse on the next clock, and the consumer must take it.
module sepconv_resample_stage
    import sepconv_resample_stage_pkg::*;
#(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNELS   = 64,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
    input  logic                           Valid_In,
    input  logic [1:0]                     Mode,
    output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
    output logic                           Valid_Out,
    output logic                           Last_Out
);

    localparam int BW = DATA_WIDHT * CHANNELS;
    localparam int CW = cnt_width(IMG_WIDHT);
    localparam int RW = cnt_width(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDHT - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    // Last even position; an odd trailing column/row has no partner.
    localparam logic [CW-1:0] COL_DEC_LAST  = CW'(((IMG_WIDHT - 1) / 2) * 2);
    localparam logic [RW-1:0] ROW_DEC_LAST  = RW'(((IMG_HEIGHT - 1) / 2) * 2);
    // Bottom-right corner of the last complete 2x2 block.
    localparam logic [CW-1:0] COL_POOL_LAST = CW'((IMG_WIDHT / 2) * 2 - 1);
    localparam logic [RW-1:0] ROW_POOL_LAST = RW'((IMG_HEIGHT / 2) * 2 - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    mode_e         active_mode;
    mode_e         mode_sel;
    mode_e         cur_mode;
    logic          first_px;
    logic          out_fire;
    logic          out_last;
    logic [BW-1:0] out_data;

    assign first_px = (col == '0) && (row == '0);

    // Map the raw Mode input onto the modes this build implements.
    always_comb begin
        mode_sel = MODE_PASS;
        case (Mode)
            2'd1:    mode_sel = MODE_DEC2;
`ifdef SEPCONV_MAXPOOL_EN
            2'd2:    mode_sel = MODE_POOL2;
`else
            2'd2:    mode_sel = MODE_DEC2;
`endif
            default: mode_sel = MODE_PASS;
        endcase
    end

    // The first pixel of a frame already obeys the mode being latched with it.
    assign cur_mode = first_px ? mode_sel : active_mode;

    // Does the current position produce an output, and is it the frame's last?
    always_comb begin
        out_fire = 1'b0;
        out_last = 1'b0;
        unique case (cur_mode)
            MODE_PASS: begin
                out_fire = 1'b1;
                out_last = (col == COL_LAST) && (row == ROW_LAST);
            end
            MODE_DEC2: begin
                out_fire = !col[0] && !row[0];
                out_last = (col == COL_DEC_LAST) && (row == ROW_DEC_LAST);
            end
            MODE_POOL2: begin
                out_fire = col[0] && row[0];
                out_last = (col == COL_POOL_LAST) && (row == ROW_POOL_LAST);
            end
            default: begin
                out_fire = 1'b0;
                out_last = 1'b0;
            end
        endcase
    end

`ifdef SEPCONV_MAXPOOL_EN
    localparam int LB_DEPTH = IMG_WIDHT / 2;
    localparam int LB_AW    = cnt_width(LB_DEPTH);

    logic [BW-1:0]    line_buf [LB_DEPTH];
    logic [BW-1:0]    prev_reg;
    logic [LB_AW-1:0] lb_idx;
    logic [BW-1:0]    lb_rd;
    logic [BW-1:0]    pmax;
    logic [BW-1:0]    pool_out;

    assign lb_idx = LB_AW'(col >> 1);
    assign lb_rd  = line_buf[lb_idx];

    // Horizontal pair max: held even-column pixel against the current one.
    sepconv_chan_max #(
        .DATA_WIDHT (DATA_WIDHT),
        .CHANNELS   (CHANNELS)
    ) u_pair_max (
        .a (prev_reg),
        .b (Data_In),
        .y (pmax)
    );

    // Vertical max: stored even-row pair max against the odd-row pair max.
    sepconv_chan_max #(
        .DATA_WIDHT (DATA_WIDHT),
        .CHANNELS   (CHANNELS)
    ) u_row_max (
        .a (lb_rd),
        .b (pmax),
        .y (pool_out)
    );

    // Not reset: every entry is rewritten before it is read in a frame.
    always_ff @(posedge clk) begin
        if (Valid_In && !col[0]) begin
            prev_reg <= Data_In;
        end
        if (Valid_In && (cur_mode == MODE_POOL2) && !row[0] && col[0]) begin
            line_buf[lb_idx] <= pmax;
        end
    end

    assign out_data = (cur_mode == MODE_POOL2) ? pool_out : Data_In;
`else
    assign out_data = Data_In;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            active_mode <= MODE_PASS;
            Valid_Out   <= 1'b0;
            Last_Out    <= 1'b0;
            Data_Out    <= '0;
        end else begin
            Valid_Out <= Valid_In && out_fire;
            Last_Out  <= Valid_In && out_fire && out_last;
            if (Valid_In) begin
                if (first_px) begin
                    active_mode <= mode_sel;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (out_fire) begin
                    Data_Out <= out_data;
                end
            end
        end
    end

endmodule
